// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle controller for the RTC multiplexed A/D port: timed address/data phases, start/busy/done handshake.
// Define RTC_BURST_EN to build multi-beat bursts with address auto-increment; otherwise every transaction is one beat.
module rtc_bus_ctrl #(
  parameter int DW      = 8,
  parameter int T_SETUP = 2,
  parameter int T_ADDR  = 8,
  parameter int T_AHOLD = 2,
  parameter int T_GAP   = 11,
  parameter int T_DATA  = 8,
  parameter int T_DHOLD = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          w_r,
  input  logic [DW-1:0] addr,
  input  logic [3:0]    burst_len,
  input  logic [DW-1:0] wdata,
  output logic          wdata_take,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  input  logic [DW-1:0] ad_in,
  output logic          a_d,
  output logic          cs_n,
  output logic          rd_n,
  output logic          wr_n
);

  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, GAP, DATA_STROBE, DATA_HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    cnt;
  logic          phase_last;
  logic          last_beat;
  logic          w_r_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          accept;
  logic          beat_end;

  assign accept   = (state == IDLE) && start;
  assign beat_end = (state == DATA_HOLD) && phase_last;

  always_comb begin
    phase_last = 1'b0;
    case (state)
      ADDR_SETUP:  phase_last = (cnt == 8'(T_SETUP - 1));
      ADDR_STROBE: phase_last = (cnt == 8'(T_ADDR - 1));
      ADDR_HOLD:   phase_last = (cnt == 8'(T_AHOLD - 1));
      GAP:         phase_last = (cnt == 8'(T_GAP - 1));
      DATA_STROBE: phase_last = (cnt == 8'(T_DATA - 1));
      DATA_HOLD:   phase_last = (cnt == 8'(T_DHOLD - 1));
      default:     phase_last = 1'b0;
    endcase
  end

`ifdef RTC_BURST_EN
  logic [3:0] beat_cnt;
  logic [3:0] burst_q;
  assign last_beat = (beat_cnt == burst_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      burst_q  <= '0;
    end else if (accept) begin
      beat_cnt <= '0;
      burst_q  <= burst_len;
    end else if (beat_end && !last_beat) begin
      beat_cnt <= beat_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      addr_q <= addr;
    else if (beat_end && !last_beat)
      addr_q <= addr_q + DW'(1);
  end
`else
  logic unused_burst_len;
  assign unused_burst_len = ^burst_len;
  assign last_beat = 1'b1;

  always_ff @(posedge clk) begin
    if (accept)
      addr_q <= addr;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start)      state_nxt = ADDR_SETUP;
      ADDR_SETUP:  if (phase_last) state_nxt = ADDR_STROBE;
      ADDR_STROBE: if (phase_last) state_nxt = ADDR_HOLD;
      ADDR_HOLD:   if (phase_last) state_nxt = GAP;
      GAP:         if (phase_last) state_nxt = DATA_STROBE;
      DATA_STROBE: if (phase_last) state_nxt = DATA_HOLD;
      DATA_HOLD:   if (phase_last) state_nxt = last_beat ? IDLE : ADDR_SETUP;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Phase counter restarts on every state change so each phase lasts exactly T_x cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (state == IDLE || state_nxt != state)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_r_q <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      if (accept)
        w_r_q <= w_r;
      done <= beat_end && last_beat;
      if (state == DATA_STROBE && phase_last && !w_r_q)
        rdata <= ad_in;
    end
  end

  always_ff @(posedge clk) begin
    if (wdata_take)
      wdata_q <= wdata;
  end

  always_comb begin
    cs_n        = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    a_d         = 1'b1;
    ad_oe       = 1'b0;
    ad_out      = '0;
    busy        = (state != IDLE);
    wdata_take  = (state == GAP) && (cnt == 8'd0) && w_r_q;
    rdata_valid = (state == DATA_HOLD) && (cnt == 8'd0) && !w_r_q;
    case (state)
      ADDR_SETUP, ADDR_HOLD: begin
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      ADDR_STROBE: begin
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
        cs_n   = 1'b0;
        wr_n   = 1'b0;
      end
      GAP, DATA_HOLD: begin
        ad_oe  = w_r_q;
        ad_out = wdata_q;
      end
      DATA_STROBE: begin
        cs_n   = 1'b0;
        ad_oe  = w_r_q;
        ad_out = wdata_q;
        wr_n   = !w_r_q;
        rd_n   = w_r_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: the driver queues expected bus events, a monitor pops and compares them.
module tb_rtc_bus_ctrl;
  localparam int ASTB = 0, WTAKE = 1, DSTB = 2, RVALID = 3, DONE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       w_r = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] bus_val = '0;
  logic [3:0] burst_len = '0;
  logic [7:0] ad_in;
  logic       wdata_take, rdata_valid, busy, done, ad_oe, a_d, cs_n, rd_n, wr_n;
  logic [7:0] rdata, ad_out;

  rtc_bus_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .w_r(w_r), .addr(addr),
    .burst_len(burst_len), .wdata(wdata), .wdata_take(wdata_take),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .a_d(a_d),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  always #5 clk = ~clk;
  assign ad_in = rd_n ? 8'h00 : bus_val;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int val;
    int aux;
  } ev_t;
  ev_t exp_q[$];

  int errors = 0;
  int checks = 0;

  function automatic string kname(input int k);
    case (k)
      ASTB:    return "addr_strobe";
      WTAKE:   return "wdata_take";
      DSTB:    return "data_strobe";
      RVALID:  return "rdata_valid";
      default: return "done";
    endcase
  endfunction

  function void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function void push_ev(input int k, input int c, input int v, input int a);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v; e.aux = a;
    exp_q.push_back(e);
  endfunction

  // aux of a strobe event = width*16 + {rd_n, wr_n, ad_oe} seen at strobe start
  function void push_txn(input int t0, input bit wr, input int a, input int wd,
                         input int rv, input int beats);
    for (int b = 0; b < beats; b++) begin
      int base;
      base = t0 + b * 34;
      push_ev(ASTB, base + 3, (a + b) & 8'hFF, 8 * 16 + 5);
      if (wr) begin
        push_ev(WTAKE, base + 13, wd, 0);
        push_ev(DSTB, base + 24, wd, 8 * 16 + 5);
      end else begin
        push_ev(DSTB, base + 24, rv, 8 * 16 + 2);
        push_ev(RVALID, base + 32, rv, 0);
      end
    end
    push_ev(DONE, t0 + beats * 34 + 1, 0, 0);
  endfunction

  function void observe(input int k, input int c, input int v, input int a);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got cycle %0d val 0x%0h aux %0d, expected no event",
               kname(k), c, v, a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != c || e.val != v || e.aux != a) begin
        errors++;
        $display("FAIL %s: got %s cycle %0d val 0x%0h aux %0d, expected %s cycle %0d val 0x%0h aux %0d",
                 kname(e.kind), kname(k), c, v, a, kname(e.kind), e.cyc, e.val, e.aux);
      end
    end
  endfunction

  // Monitor
  logic       prev_cs = 1'b1;
  int         stb_start, stb_kind, stb_val, stb_bits, stb_w;
  initial begin
    forever begin
      @(negedge clk);
      check("rd_wr_exclusive", int'(rd_n | wr_n), 1);
      if (!cs_n && prev_cs) begin
        stb_start = cyc;
        stb_kind  = a_d ? DSTB : ASTB;
        stb_val   = ad_oe ? int'(ad_out) : int'(ad_in);
        stb_bits  = {29'd0, rd_n, wr_n, ad_oe};
        stb_w     = 1;
      end else if (!cs_n) begin
        stb_w++;
      end else if (!prev_cs) begin
        observe(stb_kind, stb_start, stb_val, stb_w * 16 + stb_bits);
      end
      prev_cs = cs_n;
      if (wdata_take)  observe(WTAKE, cyc, int'(wdata), 0);
      if (rdata_valid) observe(RVALID, cyc, int'(rdata), 0);
      if (done)        observe(DONE, cyc, 0, int'(busy));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic run(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] rv, input logic [3:0] bl, input int beats);
    @(negedge clk);
    wait_idle();
    w_r = wr; addr = a; wdata = wd; bus_val = rv; burst_len = bl; start = 1'b1;
    push_txn(cyc, wr, a, wd, rv, beats);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int t0;
    #1;
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_rd_n", int'(rd_n), 1);
    check("rst_wr_n", int'(wr_n), 1);
    check("rst_a_d", int'(a_d), 1);
    check("rst_ad_oe", int'(ad_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_rdata_valid", int'(rdata_valid), 0);
    check("rst_wdata_take", int'(wdata_take), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run(1'b1, 8'h21, 8'h5A, 8'h00, 4'd0, 1);
    run(1'b0, 8'h10, 8'h00, 8'hC3, 4'd0, 1);
`ifdef RTC_BURST_EN
    run(1'b1, 8'hFE, 8'h3C, 8'h00, 4'd2, 3);
`else
    run(1'b1, 8'hFE, 8'h3C, 8'h00, 4'd3, 1);
`endif

    // start held high: second transaction only on the done cycle
    @(negedge clk);
    wait_idle();
    w_r = 1'b1; addr = 8'h40; wdata = 8'h99; burst_len = 4'd0; start = 1'b1;
    t0 = cyc;
    push_txn(t0, 1'b1, 8'h40, 8'h99, 0, 1);
    push_txn(t0 + 35, 1'b1, 8'h40, 8'h99, 0, 1);
    repeat (36) @(negedge clk);
    start = 1'b0;

    // reset during the data strobe of a write
    @(negedge clk);
    wait_idle();
    w_r = 1'b1; addr = 8'h55; wdata = 8'hA5; burst_len = 4'd0; start = 1'b1;
    t0 = cyc;
    push_ev(ASTB, t0 + 3, 8'h55, 8 * 16 + 5);
    push_ev(WTAKE, t0 + 13, 8'hA5, 0);
    push_ev(DSTB, t0 + 24, 8'hA5, 3 * 16 + 5);
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_cs_n", int'(cs_n), 1);
    check("midrst_wr_n", int'(wr_n), 1);
    check("midrst_ad_oe", int'(ad_oe), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
